// File: rtl/uart_tx_queue_pkg.sv
// Shared types and default sizing for the UART transmit queue.
package uart_tx_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } txState_t;

    localparam int TXQ_DEPTH = 16;
    localparam int TXQ_AW    = 4;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU-side and UART-side signals of the transmit queue.
// The master modport is the surroundings; the slave modport is the queue itself.
interface uart_tx_queue_if
    import uart_tx_queue_pkg::*;
#(
    parameter int AW = TXQ_AW
);
    logic          push;
    logic [7:0]    din;
    logic          flush;
    logic          clr_ovf;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;
    logic          idle;
    logic          uart_wr;
    logic [7:0]    uart_din;
    logic          uart_busy;

    modport master (
        output push, din, flush, clr_ovf, uart_busy,
        input  full, empty, level, ovf, idle, uart_wr, uart_din
    );

    modport slave (
        input  push, din, flush, clr_ovf, uart_busy,
        output full, empty, level, ovf, idle, uart_wr, uart_din
    );
endinterface

// File: rtl/uart_tx_queue_ram.sv
// DEPTH x 8 storage for the transmit queue.
// Writes are synchronous; the read is asynchronous so a launch sees the head in the same cycle.
module tx_fifo_ram
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = TXQ_DEPTH,
    parameter int AW    = TXQ_AW
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue between the CPU I/O bus and the UART transmitter.
// Bytes are drained one at a time, each launched only once the transmitter is idle.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH = TXQ_DEPTH,
    parameter int AW    = TXQ_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_queue_if.slave       bus
);
    localparam logic [AW:0] L_FULL_COUNT = (AW+1)'(DEPTH);

    txState_t      r_state;
    txState_t      w_nextState;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic          r_ovf;
    logic          r_uartWr;
    logic [7:0]    r_uartDin;

    logic          w_full;
    logic          w_empty;
    logic          w_pushOk;
    logic          w_pushDrop;
    logic          w_launch;
    logic [7:0]    w_head;

    assign w_full  = (r_count == L_FULL_COUNT);
    assign w_empty = (r_count == '0);

    // Acceptance is judged on the registered count, so a same-cycle launch cannot make room.
    assign w_pushOk   = bus.push && !w_full && !bus.flush;
    assign w_pushDrop = bus.push &&  w_full && !bus.flush;

    tx_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_pushOk),
        .i_waddr (r_wrPtr),
        .i_wdata (bus.din),
        .i_raddr (r_rdPtr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_launch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !bus.uart_busy && !bus.flush) begin
                    w_launch    = 1'b1;
                    w_nextState = ST_SEND;
                end
            end
            ST_SEND: w_nextState = ST_WAIT;
            ST_WAIT: begin
                if (!bus.uart_busy) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Flush realigns the read pointer onto the write pointer; an in-flight frame is left alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_ovf     <= 1'b0;
            r_uartWr  <= 1'b0;
            r_uartDin <= '0;
        end else begin
            r_uartWr <= w_launch;
            if (w_launch) begin
                r_uartDin <= w_head;
            end
            if (bus.flush) begin
                r_rdPtr <= r_wrPtr;
                r_count <= '0;
            end else begin
                if (w_pushOk) begin
                    r_wrPtr <= r_wrPtr + AW'(1);
                end
                if (w_launch) begin
                    r_rdPtr <= r_rdPtr + AW'(1);
                end
                r_count <= r_count + {{AW{1'b0}}, w_pushOk} - {{AW{1'b0}}, w_launch};
            end
            if (w_pushDrop) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_count;
    assign bus.ovf      = r_ovf;
    assign bus.idle     = w_empty && (r_state == ST_IDLE) && !bus.uart_busy;
    assign bus.uart_wr  = r_uartWr;
    assign bus.uart_din = r_uartDin;
endmodule
